lcd_init_sequencer: RTL and testbench
=====================================

Name: lcd_init_sequencer

Overview:
Power-up and configuration controller for the LCD panel. Drives the panel reset and clock-enable timing, then polls the HW config register over the serial transceiver until it reads the expected ID. It then plays a fixed table of register writes through the transceiver and asserts ready, which releases the pixel streamer into normal frame output. It is the only master of the transceiver's begin/address/data inputs.

Parameters:
RESET_LOW_CYCLES, 20, cycles nreset held low with clock gated (≥100 ns at 140 MHz)
RESET_WAIT_CYCLES, 970000, cycles after nreset release before first serial access (datasheet min 960000)
HW_CONFIG_ADDRESS, 7'h78, register polled for panel ID
HW_CONFIG_EXPECTED, 8'h20, ID value that passes the poll
POLL_INTERVAL, 1000000, idle cycles between failed polls
MAX_POLLS, 8, failed polls before error
NUM_WRITES, 4, entries in the write table (1..16)
DONE_TIMEOUT, 4096, max cycles waiting for a transceiver done pulse

Ports:
i_clock  in  1  system clock (PLL output)
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  level; sequence runs while high; low forces return to S_HOLD_RESET
o_nreset  out  1  panel reset, active low
o_clockEnable  out  1  gates the panel pixel clock
o_txBegin  out  1  one-cycle pulse, start transceiver write
o_rxBegin  out  1  one-cycle pulse, start transceiver read
o_address  out  7  transceiver register address
o_txData  out  8  transceiver write data
i_txDone  in  1  one-cycle pulse, write finished
i_rxDone  in  1  one-cycle pulse, read finished, i_rxData valid
i_rxData  in  8  read data
o_ready  out  1  high when configuration is complete
o_error  out  1  sticky; ID mismatch after MAX_POLLS, or timeout
o_lastId  out  8  last ID read (debug/UART)

Behaviour:
- Reset values: o_nreset=0, o_clockEnable=0, o_txBegin=0, o_rxBegin=0, o_address=0, o_txData=0, o_ready=0, o_error=0, o_lastId=0; state S_HOLD_RESET; all counters 0.
- All outputs registered; state updates on rising i_clock.
- S_HOLD_RESET: nreset=0, clockEnable=0. When i_start=1, count to RESET_LOW_CYCLES-1, then go to S_RESET_WAIT.
- S_RESET_WAIT: nreset=1, clockEnable=1. Count RESET_WAIT_CYCLES, then go to S_POLL_REQ. nreset and clockEnable stay 1 in every later state except S_HOLD_RESET.
- S_POLL_REQ: o_address=HW_CONFIG_ADDRESS, o_rxBegin=1 for exactly one cycle, then go to S_POLL_WAIT.
- S_POLL_WAIT: on i_rxDone, latch o_lastId=i_rxData. If it equals EXPECTED, clear the poll count and go to S_WRITE_REQ with index 0. Otherwise increment the poll count: at MAX_POLLS go to S_ERROR, else go to S_POLL_DELAY.
- S_POLL_DELAY: wait POLL_INTERVAL cycles, then go to S_POLL_REQ.
- S_WRITE_REQ: o_address/o_txData come from table[index]; o_txBegin pulses one cycle; then go to S_WRITE_WAIT.
- S_WRITE_WAIT: on i_txDone, if index==NUM_WRITES-1 go to S_READY, else index+1 and go to S_WRITE_REQ.
- Minimum gap between consecutive begin pulses is 2 cycles; only one of txBegin/rxBegin is ever high.
- Done timeout: a counter clears on entering a *_WAIT state. Reaching DONE_TIMEOUT goes to S_ERROR.
- Done pulses arriving outside the matching *_WAIT state are ignored. A done pulse on the same cycle as the timeout is accepted (done wins).
- S_READY: o_ready=1; hold until i_start falls.
- S_ERROR: o_error=1, o_ready=0; hold until i_start falls.
- i_start falling in any state: next cycle go to S_HOLD_RESET. Outputs become nreset=0, clockEnable=0, ready=0. o_error holds its value and clears on the next i_start rise. A transfer in flight is abandoned and its late done is ignored.
- Counter width is 20 bits minimum, sized from the largest of the cycle parameters.
- Async i_reset mid-operation returns to the reset values immediately.

Decomposition:
- Shared package lcd_pkg holds:
  - state encoding
  - HW_CONFIG_ADDRESS
  - ID constant
  - table entry typedef {addr[6:0], data[7:0]}
- Sub-module lcd_init_rom: combinational index[3:0] to {addr, data} containing the write table, so the panel setup can change without touching the FSM.

Test Plan:
Use small parameters throughout: RESET_LOW_CYCLES=4, RESET_WAIT_CYCLES=10, POLL_INTERVAL=5, MAX_POLLS=3, DONE_TIMEOUT=20.
1. Nominal: raise i_start; model returns 8'h20 on the first read -> nreset low 4 cycles then high; first rxBegin 10 cycles later with addr 7'h78; 4 txBegin pulses matching the ROM; o_ready=1; o_lastId=8'h20.
2. ID retry: model returns 8'h00, 8'h00, 8'h20 -> 3 rxBegin pulses spaced by ≥5 idle cycles; no error; o_ready=1.
3. ID failure: model always returns 8'h11 -> exactly 3 polls, o_error=1, o_ready=0, no txBegin ever, o_lastId=8'h11.
4. Timeout: model never asserts i_txDone on write 2 -> o_error=1 exactly 20 cycles after the second txBegin.
5. Abort: drop i_start during S_WRITE_WAIT, then give a late i_txDone -> next cycle nreset=0, clockEnable=0; late done ignored; re-raising i_start replays the full sequence.
6. Async reset: assert i_reset mid-poll, between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD power-up / configuration sequencer.
package lcd_pkg;

   // Sequencer states; exported on the debug state port of the top.
   typedef enum logic [3:0] {
      S_HOLD_RESET = 4'd0,
      S_RESET_WAIT = 4'd1,
      S_POLL_REQ   = 4'd2,
      S_POLL_WAIT  = 4'd3,
      S_POLL_DELAY = 4'd4,
      S_WRITE_REQ  = 4'd5,
      S_WRITE_WAIT = 4'd6,
      S_READY      = 4'd7,
      S_ERROR      = 4'd8
   } state_t;

   // Panel ID register and the value that identifies a supported panel.
   localparam logic [6:0] HW_CONFIG_ADDRESS  = 7'h78;
   localparam logic [7:0] HW_CONFIG_EXPECTED = 8'h20;

   // One entry of the register write table.
   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] data;
   } tableEntry_t;

   // Larger of two values; used for sizing counters at elaboration.
   function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel register write table. Changing the panel setup only touches this file.
module lcd_init_rom
   import lcd_pkg::*;
(
   input  logic [3:0]  index,
   output tableEntry_t entry
);

   // Combinational lookup; unused indices read as all-zero.
   always_comb begin
      entry = '{addr: 7'h00, data: 8'h00};
      case (index)
         4'd0:    entry = '{addr: 7'h10, data: 8'h01};
         4'd1:    entry = '{addr: 7'h11, data: 8'h3C};
         4'd2:    entry = '{addr: 7'h20, data: 8'hA5};
         4'd3:    entry = '{addr: 7'h36, data: 8'h80};
         default: entry = '{addr: 7'h00, data: 8'h00};
      endcase
   end

endmodule

// File: rtl/lcd_init_sequencer.sv
// Power-up and configuration controller for the LCD panel: reset/clock-enable
// timing, panel ID polling, then a fixed table of register writes.
//
// Transceiver handshake: o_txBegin / o_rxBegin are single-cycle request
// pulses, never high together and at least two cycles apart. The transceiver
// answers with a single-cycle i_txDone / i_rxDone pulse (i_rxData valid with
// i_rxDone). A done pulse is honoured only in the matching *_WAIT state; any
// other done pulse (late, stray, after an abort) is dropped.
module lcd_init_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned RESET_LOW_CYCLES  = 20,
   parameter int unsigned RESET_WAIT_CYCLES = 970000,
   parameter int unsigned POLL_INTERVAL     = 1000000,
   parameter int unsigned MAX_POLLS         = 8,
   parameter int unsigned NUM_WRITES        = 4,
   parameter int unsigned DONE_TIMEOUT      = 4096
)(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   output logic       o_nreset,
   output logic       o_clockEnable,
   output logic       o_txBegin,
   output logic       o_rxBegin,
   output logic [6:0] o_address,
   output logic [7:0] o_txData,
   input  logic       i_txDone,
   input  logic       i_rxDone,
   input  logic [7:0] i_rxData,
   output logic       o_ready,
   output logic       o_error,
   output logic [7:0] o_lastId,
   output state_t     o_debugState
);

   localparam int unsigned MAX_CYCLES = maxOf(maxOf(RESET_LOW_CYCLES, RESET_WAIT_CYCLES),
                                              maxOf(POLL_INTERVAL, DONE_TIMEOUT));
   localparam int unsigned CNT_W  = maxOf(20, $clog2(MAX_CYCLES + 1));
   localparam int unsigned POLL_W = maxOf(1, $clog2(MAX_POLLS));

   localparam logic [CNT_W-1:0]  LOW_LAST   = CNT_W'(RESET_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(RESET_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(POLL_INTERVAL - 1);
   // The begin cycle counts as the first cycle of a transfer, so the error
   // lands exactly DONE_TIMEOUT cycles after the begin pulse (DONE_TIMEOUT >= 2).
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 2);
   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(MAX_POLLS - 1);
   localparam logic [3:0]        LAST_INDEX = 4'(NUM_WRITES - 1);

   state_t            state, nextState;
   logic [CNT_W-1:0]  cnt, nextCnt;
   logic [3:0]        index, nextIndex;
   logic [POLL_W-1:0] pollCount, nextPolls;
   logic              latchId;
   logic              startQ;
   tableEntry_t       romEntry;

   lcd_init_rom u_rom (
      .index (nextIndex),
      .entry (romEntry)
   );

   assign o_debugState = state;

   // Next-state, counter, table index and poll count decisions.
   always_comb begin
      nextState = state;
      nextCnt   = cnt + 1'b1;
      nextIndex = index;
      nextPolls = pollCount;
      latchId   = 1'b0;
      case (state)
         S_HOLD_RESET: begin
            nextPolls = '0;
            if (!i_start) begin
               nextCnt = '0;
            end else if (cnt == LOW_LAST) begin
               nextState = S_RESET_WAIT;
            end
         end
         S_RESET_WAIT: begin
            if (cnt == WAIT_LAST) nextState = S_POLL_REQ;
         end
         S_POLL_REQ: begin
            nextState = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            // Done wins over a timeout on the same cycle.
            if (i_rxDone) begin
               latchId = i_start;
               if (i_rxData == HW_CONFIG_EXPECTED) begin
                  nextPolls = '0;
                  nextIndex = '0;
                  nextState = S_WRITE_REQ;
               end else if (pollCount == POLL_LAST) begin
                  nextState = S_ERROR;
               end else begin
                  nextPolls = pollCount + 1'b1;
                  nextState = S_POLL_DELAY;
               end
            end else if (cnt == TIMEOUT_LAST) begin
               nextState = S_ERROR;
            end
         end
         S_POLL_DELAY: begin
            if (cnt == DELAY_LAST) nextState = S_POLL_REQ;
         end
         S_WRITE_REQ: begin
            nextState = S_WRITE_WAIT;
         end
         S_WRITE_WAIT: begin
            if (i_txDone) begin
               if (index == LAST_INDEX) begin
                  nextState = S_READY;
               end else begin
                  nextIndex = index + 4'd1;
                  nextState = S_WRITE_REQ;
               end
            end else if (cnt == TIMEOUT_LAST) begin
               nextState = S_ERROR;
            end
         end
         S_READY, S_ERROR: begin
            nextCnt = '0;
         end
         default: begin
            nextState = S_HOLD_RESET;
         end
      endcase
      // Dropping i_start abandons whatever is in progress.
      if (!i_start) nextState = S_HOLD_RESET;
      // Every state measures its time from its own entry.
      if (nextState != state) nextCnt = '0;
   end

   // State and bookkeeping registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state     <= S_HOLD_RESET;
         cnt       <= '0;
         index     <= '0;
         pollCount <= '0;
         startQ    <= 1'b0;
      end else begin
         state     <= nextState;
         cnt       <= nextCnt;
         index     <= nextIndex;
         pollCount <= nextPolls;
         startQ    <= i_start;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_nreset      <= 1'b0;
         o_clockEnable <= 1'b0;
         o_txBegin     <= 1'b0;
         o_rxBegin     <= 1'b0;
         o_address     <= '0;
         o_txData      <= '0;
         o_ready       <= 1'b0;
         o_error       <= 1'b0;
         o_lastId      <= '0;
      end else begin
         o_nreset      <= (nextState != S_HOLD_RESET);
         o_clockEnable <= (nextState != S_HOLD_RESET);
         o_rxBegin     <= (nextState == S_POLL_REQ);
         o_txBegin     <= (nextState == S_WRITE_REQ);
         o_ready       <= (nextState == S_READY);
         if (nextState == S_POLL_REQ) begin
            o_address <= HW_CONFIG_ADDRESS;
         end else if (nextState == S_WRITE_REQ) begin
            o_address <= romEntry.addr;
            o_txData  <= romEntry.data;
         end
         if (latchId) o_lastId <= i_rxData;
         // Sticky error: survives i_start falling, cleared by the next rise.
         if (nextState == S_ERROR) begin
            o_error <= 1'b1;
         end else if (i_start && !startQ) begin
            o_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with a small transceiver model.
module tb_lcd_init_sequencer;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       nreset, clockEnable, txBegin, rxBegin, ready, error;
   logic [6:0] address;
   logic [7:0] txData, lastId;
   logic       txDone = 1'b0;
   logic       rxDone = 1'b0;
   logic [7:0] rxData = 8'h00;
   state_t     dbgState;

   // Clock / reset
   always #5 clk = ~clk;

   lcd_init_sequencer #(
      .RESET_LOW_CYCLES  (4),
      .RESET_WAIT_CYCLES (10),
      .POLL_INTERVAL     (5),
      .MAX_POLLS         (3),
      .NUM_WRITES        (4),
      .DONE_TIMEOUT      (20)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start       (start),
      .o_nreset      (nreset),
      .o_clockEnable (clockEnable),
      .o_txBegin     (txBegin),
      .o_rxBegin     (rxBegin),
      .o_address     (address),
      .o_txData      (txData),
      .i_txDone      (txDone),
      .i_rxDone      (rxDone),
      .i_rxData      (rxData),
      .o_ready       (ready),
      .o_error       (error),
      .o_lastId      (lastId),
      .o_debugState  (dbgState)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int startCyc = 0;

   // Transceiver model state and logs
   logic [7:0]  idQ[$];
   logic [7:0]  defaultId = 8'h20;
   int          rxPending = 0;
   int          txPending = 0;
   int          dropTx = 0;
   bit          injectTx = 1'b0;
   int          rxCount = 0;
   int          txCount = 0;
   int          rxCyc[$];
   int          txCyc[$];
   logic [6:0]  rxAddr[$];
   logic [14:0] txLog[$];
   logic [14:0] exp_q[$];
   int          bothBegin = 0;
   int          nresetRiseCyc = -1;
   int          errRiseCyc = -1;
   logic        prevNreset = 1'b0;
   logic        prevErr = 1'b0;

   // Transceiver model: works on the falling edge, done two cycles after begin.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         rxDone = 1'b0;
         txDone = 1'b0;
         if (rxPending > 0) begin
            rxPending--;
            if (rxPending == 0) begin
               rxDone = 1'b1;
               rxData = (idQ.size() > 0) ? idQ.pop_front() : defaultId;
            end
         end
         if (txPending > 0) begin
            txPending--;
            if (txPending == 0) txDone = 1'b1;
         end
         if (injectTx) begin
            txDone = 1'b1;
            injectTx = 1'b0;
         end
         if (rxBegin) begin
            rxCount++;
            rxCyc.push_back(cyc);
            rxAddr.push_back(address);
            rxPending = 2;
         end
         if (txBegin) begin
            txCount++;
            txCyc.push_back(cyc);
            txLog.push_back({address, txData});
            if (txCount != dropTx) txPending = 2;
         end
         if (rxBegin && txBegin) bothBegin++;
         if (nreset && !prevNreset) nresetRiseCyc = cyc;
         if (error && !prevErr) errRiseCyc = cyc;
         prevNreset = nreset;
         prevErr = error;
      end
   end

   // Scoreboard compare point
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic stepCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clearLogs();
      idQ.delete(); rxCyc.delete(); txCyc.delete(); rxAddr.delete(); txLog.delete();
      rxCount = 0; txCount = 0; rxPending = 0; txPending = 0; dropTx = 0;
      bothBegin = 0; nresetRiseCyc = -1; errRiseCyc = -1;
   endtask

   task automatic raiseStart();
      start = 1'b1;
      startCyc = cyc;
   endtask

   task automatic dropStart();
      start = 1'b0;
      stepCycles(3);
   endtask

   task automatic waitReadyOrError(input string tag);
      int n = 0;
      while (!(ready || error) && n < 400) begin
         stepCycles(1);
         n++;
      end
      checkVal({tag, "_bounded"}, 32'(n < 400), 32'd1);
   endtask

   task automatic loadExpected();
      exp_q.delete();
      exp_q.push_back({7'h10, 8'h01});
      exp_q.push_back({7'h11, 8'h3C});
      exp_q.push_back({7'h20, 8'hA5});
      exp_q.push_back({7'h36, 8'h80});
   endtask

   task automatic compareWrites(input string tag);
      checkVal({tag, "_txcount"}, 32'(txCount), 32'd4);
      foreach (exp_q[i]) begin
         if (i < txLog.size()) checkVal($sformatf("%s_write%0d", tag, i), 32'(txLog[i]), 32'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      stepCycles(3);
      rst = 1'b0;
      stepCycles(2);
      checkVal("rst_nreset", 32'(nreset), 32'd0);
      checkVal("rst_clockEnable", 32'(clockEnable), 32'd0);
      checkVal("rst_ready", 32'(ready), 32'd0);
      checkVal("rst_error", 32'(error), 32'd0);
      checkVal("rst_lastId", 32'(lastId), 32'd0);
      checkVal("rst_address", 32'(address), 32'd0);
      checkVal("rst_state", 32'(dbgState), 32'(S_HOLD_RESET));

      // 1. Nominal bring-up
      clearLogs();
      defaultId = 8'h20;
      loadExpected();
      raiseStart();
      waitReadyOrError("nom");
      checkVal("nom_nreset_low", 32'(nresetRiseCyc - startCyc), 32'd4);
      checkVal("nom_first_poll", 32'(rxCyc.size() > 0 ? rxCyc[0] - nresetRiseCyc : -1), 32'd10);
      checkVal("nom_poll_addr", 32'(rxAddr.size() > 0 ? rxAddr[0] : 7'h00), 32'h78);
      checkVal("nom_rxcount", 32'(rxCount), 32'd1);
      compareWrites("nom");
      checkVal("nom_ready", 32'(ready), 32'd1);
      checkVal("nom_error", 32'(error), 32'd0);
      checkVal("nom_lastId", 32'(lastId), 32'h20);
      checkVal("nom_clockEnable", 32'(clockEnable), 32'd1);
      checkVal("nom_both_begin", 32'(bothBegin), 32'd0);

      // 2. ID retry: two wrong IDs then the right one
      dropStart();
      checkVal("drop_ready", 32'(ready), 32'd0);
      checkVal("drop_nreset", 32'(nreset), 32'd0);
      clearLogs();
      idQ = '{8'h00, 8'h00, 8'h20};
      loadExpected();
      raiseStart();
      waitReadyOrError("retry");
      checkVal("retry_rxcount", 32'(rxCount), 32'd3);
      checkVal("retry_gap1", 32'(rxCyc.size() > 1 ? rxCyc[1] - rxCyc[0] : -1), 32'd8);
      checkVal("retry_gap2", 32'(rxCyc.size() > 2 ? rxCyc[2] - rxCyc[1] : -1), 32'd8);
      checkVal("retry_ready", 32'(ready), 32'd1);
      checkVal("retry_error", 32'(error), 32'd0);
      compareWrites("retry");

      // 3. ID failure: never the right ID
      dropStart();
      clearLogs();
      defaultId = 8'h11;
      raiseStart();
      waitReadyOrError("idfail");
      checkVal("idfail_rxcount", 32'(rxCount), 32'd3);
      checkVal("idfail_error", 32'(error), 32'd1);
      checkVal("idfail_ready", 32'(ready), 32'd0);
      checkVal("idfail_txcount", 32'(txCount), 32'd0);
      checkVal("idfail_lastId", 32'(lastId), 32'h11);
      checkVal("idfail_state", 32'(dbgState), 32'(S_ERROR));

      // 4. Done timeout on the second write
      dropStart();
      checkVal("err_sticky", 32'(error), 32'd1);
      clearLogs();
      defaultId = 8'h20;
      dropTx = 2;
      raiseStart();
      stepCycles(1);
      checkVal("err_cleared", 32'(error), 32'd0);
      waitReadyOrError("tmo");
      checkVal("tmo_error", 32'(error), 32'd1);
      checkVal("tmo_ready", 32'(ready), 32'd0);
      checkVal("tmo_txcount", 32'(txCount), 32'd2);
      checkVal("tmo_latency", 32'(txCyc.size() > 1 ? errRiseCyc - txCyc[1] : -1), 32'd20);

      // 5. Abort during a write, late done ignored, then full replay
      dropStart();
      clearLogs();
      dropTx = 3;
      raiseStart();
      begin
         int n = 0;
         while (txCount < 3 && n < 200) begin
            stepCycles(1);
            n++;
         end
         checkVal("abort_reach_write3", 32'(n < 200), 32'd1);
      end
      stepCycles(2);
      checkVal("abort_in_wait", 32'(dbgState), 32'(S_WRITE_WAIT));
      start = 1'b0;
      stepCycles(1);
      checkVal("abort_nreset", 32'(nreset), 32'd0);
      checkVal("abort_clockEnable", 32'(clockEnable), 32'd0);
      checkVal("abort_state", 32'(dbgState), 32'(S_HOLD_RESET));
      injectTx = 1'b1;
      stepCycles(5);
      checkVal("late_done_state", 32'(dbgState), 32'(S_HOLD_RESET));
      checkVal("late_done_error", 32'(error), 32'd0);
      checkVal("late_done_ready", 32'(ready), 32'd0);
      clearLogs();
      loadExpected();
      raiseStart();
      waitReadyOrError("replay");
      checkVal("replay_nreset_low", 32'(nresetRiseCyc - startCyc), 32'd4);
      checkVal("replay_rxcount", 32'(rxCount), 32'd1);
      compareWrites("replay");
      checkVal("replay_ready", 32'(ready), 32'd1);

      // 6. Async reset in the middle of a poll
      dropStart();
      clearLogs();
      idQ = '{8'h33};
      raiseStart();
      begin
         int n = 0;
         while (rxCount < 1 && n < 200) begin
            stepCycles(1);
            n++;
         end
         checkVal("arst_reach_poll", 32'(n < 200), 32'd1);
      end
      #2;
      rst = 1'b1;
      #1;
      checkVal("arst_nreset", 32'(nreset), 32'd0);
      checkVal("arst_clockEnable", 32'(clockEnable), 32'd0);
      checkVal("arst_rxBegin", 32'(rxBegin), 32'd0);
      checkVal("arst_txBegin", 32'(txBegin), 32'd0);
      checkVal("arst_address", 32'(address), 32'd0);
      checkVal("arst_txData", 32'(txData), 32'd0);
      checkVal("arst_ready", 32'(ready), 32'd0);
      checkVal("arst_error", 32'(error), 32'd0);
      checkVal("arst_lastId", 32'(lastId), 32'd0);
      checkVal("arst_state", 32'(dbgState), 32'(S_HOLD_RESET));
      start = 1'b0;
      stepCycles(2);
      rst = 1'b0;
      stepCycles(2);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
